// File: rtl/microwave_ctrl.sv
// Microwave sequencing controller: BCD cook-time entry, countdown, magnetron gating.
// Optional door interlock is compiled in with `define MW_DOOR_INTERLOCK_EN.
module microwave_ctrl #(
    parameter int unsigned DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1hz,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic       enablen,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_COOK,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [3:0] DONE_LAST = 4'(DONE_TICKS - 1);
    // Bit order {stopn, startn, pgt_1hz, loadn}; active-low buttons idle high.
    localparam logic [3:0] SYNC_RST = 4'b1110;

    state_t     state_q, state_d;
    logic [3:0] min_q, min_d;
    logic [3:0] ten_q, ten_d;
    logic [3:0] one_q, one_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] mask_q, mask_d;
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] prev_q, prev_d;

    logic key_ev, tick_ev, start_ev, stop_ev;
    logic ilk_ok;
    logic time_nz;
    logic at_one_sec;

`ifdef MW_DOOR_INTERLOCK_EN
    logic door_s1_q, door_s2_q;

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            door_s1_q <= 1'b0;
            door_s2_q <= 1'b0;
        end else begin
            door_s1_q <= door_closed;
            door_s2_q <= door_s1_q;
        end
    end

    assign ilk_ok = door_s2_q;
`else
    logic unused_door;
    assign unused_door = door_closed;
    assign ilk_ok      = 1'b1;
`endif

    function automatic logic sel_div(input state_t s);
        return (s == S_COOK) || (s == S_PAUSE) || (s == S_DONE);
    endfunction

    assign key_ev     = prev_q[0] & ~sync2_q[0];
    assign tick_ev    = ~prev_q[1] & sync2_q[1] & (mask_q == 3'd0);
    assign start_ev   = prev_q[2] & ~sync2_q[2];
    assign stop_ev    = prev_q[3] & ~sync2_q[3];
    assign time_nz    = |{min_q, ten_q, one_q};
    assign at_one_sec = ({min_q, ten_q, one_q} == 12'h001);

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_q <= S_IDLE;
            min_q   <= 4'd0;
            ten_q   <= 4'd0;
            one_q   <= 4'd0;
            cnt_q   <= 4'd0;
            mask_q  <= 3'd0;
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
            prev_q  <= SYNC_RST;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            ten_q   <= ten_d;
            one_q   <= one_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        ten_d   = ten_q;
        one_d   = one_q;
        cnt_d   = cnt_q;
        mask_d  = (mask_q != 3'd0) ? mask_q - 3'd1 : 3'd0;
        sync1_d = {stopn, startn, pgt_1hz, loadn};
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (stop_ev) begin
                    state_d = S_IDLE;
                    min_d   = 4'd0;
                    ten_d   = 4'd0;
                    one_d   = 4'd0;
                end else if (start_ev) begin
                    if (time_nz && ilk_ok) begin
                        state_d = S_COOK;
                    end
                end else if (key_ev && (D <= 4'd9) && (one_q <= 4'd5)) begin
                    state_d = S_ENTRY;
                    min_d   = ten_q;
                    ten_d   = one_q;
                    one_d   = D;
                end
            end
            S_COOK: begin
                if (stop_ev || !ilk_ok) begin
                    state_d = S_PAUSE;
                end else if (tick_ev) begin
                    if (one_q != 4'd0) begin
                        one_d = one_q - 4'd1;
                    end else begin
                        one_d = 4'd9;
                        if (ten_q != 4'd0) begin
                            ten_d = ten_q - 4'd1;
                        end else begin
                            ten_d = 4'd5;
                            min_d = min_q - 4'd1;
                        end
                    end
                    if (at_one_sec) begin
                        state_d = S_DONE;
                        cnt_d   = 4'd0;
                    end
                end
            end
            S_PAUSE: begin
                if (stop_ev) begin
                    state_d = S_IDLE;
                    min_d   = 4'd0;
                    ten_d   = 4'd0;
                    one_d   = 4'd0;
                end else if (start_ev && ilk_ok) begin
                    state_d = S_COOK;
                end
            end
            S_DONE: begin
                if (stop_ev) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (tick_ev) begin
                    if (cnt_q == DONE_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The encoder mux glitches while switching to the divider; hide those edges.
        if (!sel_div(state_q) && sel_div(state_d)) begin
            mask_d = 3'd4;
        end
    end

    always_comb begin
        enablen  = sel_div(state_q);
        mag_on   = (state_q == S_COOK);
        done     = (state_q == S_DONE);
        min_ones = min_q;
        sec_tens = ten_q;
        sec_ones = one_q;
    end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed testbench for microwave_ctrl: vector table plus hand-written latency,
// mask, simultaneous-event, done-hold, async-reset and door sequences.
module tb_microwave_ctrl;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_KEY,
        OP_START,
        OP_STOP,
        OP_TICK
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [3:0] d;
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] s;
        logic       mag;
        logic       en;
        logic       dn;
    } vec_t;

    localparam int NV = 28;

    logic       clk;
    logic       clearn;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1hz;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic       enablen;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       mag_on;
    logic       done;

    int   checks;
    int   errors;
    vec_t vecs [0:NV-1];

    microwave_ctrl #(.DONE_TICKS(3)) dut (
        .clk         (clk),
        .clearn      (clearn),
        .D           (D),
        .loadn       (loadn),
        .pgt_1hz     (pgt_1hz),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .enablen     (enablen),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .mag_on      (mag_on),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each operation is a 4-cycle assertion plus 4-cycle release so outputs settle.
    task automatic applyStimulus(input op_t op, input logic [3:0] d);
        case (op)
            OP_KEY: begin
                D = d;
                loadn = 1'b0;
                waitCycles(4);
                loadn = 1'b1;
                waitCycles(4);
            end
            OP_START: begin
                startn = 1'b0;
                waitCycles(4);
                startn = 1'b1;
                waitCycles(4);
            end
            OP_STOP: begin
                stopn = 1'b0;
                waitCycles(4);
                stopn = 1'b1;
                waitCycles(4);
            end
            OP_TICK: begin
                pgt_1hz = 1'b1;
                waitCycles(4);
                pgt_1hz = 1'b0;
                waitCycles(4);
            end
            default: waitCycles(8);
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [3:0] em, input logic [3:0] et,
                               input logic [3:0] es, input logic emag, input logic een,
                               input logic edn);
        checks++;
        if ({min_ones, sec_tens, sec_ones, mag_on, enablen, done} !== {em, et, es, emag, een, edn}) begin
            errors++;
            $display("[TB] FAIL %s: got %0d:%0d%0d mag_on=%b enablen=%b done=%b, expected %0d:%0d%0d mag_on=%b enablen=%b done=%b",
                     name, min_ones, sec_tens, sec_ones, mag_on, enablen, done,
                     em, et, es, emag, een, edn);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{OP_KEY,   4'd1,  4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{OP_KEY,   4'd3,  4'd0, 4'd1, 4'd3, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{OP_KEY,   4'd0,  4'd1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{OP_KEY,   4'd0,  4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_KEY,   4'd12, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{OP_STOP,  4'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_KEY,   4'd7,  4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_KEY,   4'd4,  4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_START, 4'd0,  4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{OP_TICK,  4'd0,  4'd0, 4'd0, 4'd6, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{OP_KEY,   4'd5,  4'd0, 4'd0, 4'd6, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{OP_STOP,  4'd0,  4'd0, 4'd0, 4'd6, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{OP_TICK,  4'd0,  4'd0, 4'd0, 4'd6, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{OP_START, 4'd0,  4'd0, 4'd0, 4'd6, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{OP_STOP,  4'd0,  4'd0, 4'd0, 4'd6, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{OP_STOP,  4'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{OP_START, 4'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{OP_KEY,   4'd2,  4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{OP_KEY,   4'd0,  4'd0, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{OP_START, 4'd0,  4'd0, 4'd2, 4'd0, 1'b1, 1'b1, 1'b0};
        vecs[20] = '{OP_TICK,  4'd0,  4'd0, 4'd1, 4'd9, 1'b1, 1'b1, 1'b0};
        vecs[21] = '{OP_STOP,  4'd0,  4'd0, 4'd1, 4'd9, 1'b0, 1'b1, 1'b0};
        vecs[22] = '{OP_STOP,  4'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[23] = '{OP_KEY,   4'd1,  4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[24] = '{OP_KEY,   4'd0,  4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[25] = '{OP_KEY,   4'd0,  4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[26] = '{OP_START, 4'd0,  4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0};
        vecs[27] = '{OP_TICK,  4'd0,  4'd0, 4'd5, 4'd9, 1'b1, 1'b1, 1'b0};

        clearn      = 1'b0;
        D           = 4'd0;
        loadn       = 1'b1;
        pgt_1hz     = 1'b0;
        startn      = 1'b1;
        stopn       = 1'b1;
        door_closed = 1'b1;
        waitCycles(3);
        checkOutput("reset_state", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        clearn = 1'b1;
        waitCycles(2);

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].op, vecs[i].d);
            checkOutput($sformatf("vec%0d", i), vecs[i].m, vecs[i].t, vecs[i].s,
                        vecs[i].mag, vecs[i].en, vecs[i].dn);
        end

        // Count the rest of the minute down to 0:00, then hold done for three ticks.
        for (int k = 58; k >= 1; k--) begin
            applyStimulus(OP_TICK, 4'd0);
            checkOutput($sformatf("count_%0d", k), 4'd0, 4'(k / 10), 4'(k % 10), 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(OP_TICK, 4'd0);
        checkOutput("reach_done", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(OP_TICK, 4'd0);
        checkOutput("done_tick1", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(OP_TICK, 4'd0);
        checkOutput("done_tick2", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(OP_TICK, 4'd0);
        checkOutput("done_to_idle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // A tick edge right after start lands inside the mux mask and must be dropped.
        applyStimulus(OP_KEY, 4'd9);
        startn = 1'b0;
        waitCycles(1);
        pgt_1hz = 1'b1;
        waitCycles(3);
        startn = 1'b1;
        waitCycles(4);
        pgt_1hz = 1'b0;
        waitCycles(4);
        checkOutput("tick_masked", 4'd0, 4'd0, 4'd9, 1'b1, 1'b1, 1'b0);
        applyStimulus(OP_TICK, 4'd0);
        checkOutput("tick_after_mask", 4'd0, 4'd0, 4'd8, 1'b1, 1'b1, 1'b0);
        applyStimulus(OP_STOP, 4'd0);
        applyStimulus(OP_STOP, 4'd0);
        checkOutput("mask_cleanup", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Start latency with a long-held button.
        applyStimulus(OP_KEY, 4'd5);
        startn = 1'b0;
        waitCycles(1);
        checkOutput("start_lat1", 4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("start_lat2", 4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("start_lat3", 4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0);
        waitCycles(10);
        startn = 1'b1;
        waitCycles(4);
        checkOutput("start_held", 4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0);

        // Tick and stop in the same cycle: pause without decrementing.
        pgt_1hz = 1'b1;
        stopn   = 1'b0;
        waitCycles(4);
        pgt_1hz = 1'b0;
        stopn   = 1'b1;
        waitCycles(4);
        checkOutput("tick_stop_pause", 4'd0, 4'd0, 4'd5, 1'b0, 1'b1, 1'b0);
        applyStimulus(OP_STOP, 4'd0);
        checkOutput("pause_stop_idle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of cooking.
        applyStimulus(OP_KEY, 4'd4);
        applyStimulus(OP_KEY, 4'd2);
        applyStimulus(OP_START, 4'd0);
        checkOutput("cook_042", 4'd0, 4'd4, 4'd2, 1'b1, 1'b1, 1'b0);
        #2 clearn = 1'b0;
        #1 checkOutput("reset_async", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clearn = 1'b1;
        waitCycles(2);
        checkOutput("reset_release", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        applyStimulus(OP_KEY, 4'd1);
        applyStimulus(OP_KEY, 4'd1);
        applyStimulus(OP_START, 4'd0);
`ifdef MW_DOOR_INTERLOCK_EN
        applyStimulus(OP_TICK, 4'd0);
        checkOutput("door_cook_010", 4'd0, 4'd1, 4'd0, 1'b1, 1'b1, 1'b0);
        door_closed = 1'b0;
        waitCycles(2);
        checkOutput("door_lat2", 4'd0, 4'd1, 4'd0, 1'b1, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("door_lat3", 4'd0, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0);
        waitCycles(5);
        applyStimulus(OP_START, 4'd0);
        checkOutput("start_door_open", 4'd0, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0);
        door_closed = 1'b1;
        waitCycles(4);
        applyStimulus(OP_START, 4'd0);
        checkOutput("door_resume", 4'd0, 4'd1, 4'd0, 1'b1, 1'b1, 1'b0);
`else
        door_closed = 1'b0;
        waitCycles(8);
        checkOutput("door_ignored", 4'd0, 4'd1, 4'd1, 1'b1, 1'b1, 1'b0);
        applyStimulus(OP_TICK, 4'd0);
        checkOutput("door_ignored_tick", 4'd0, 4'd1, 4'd0, 1'b1, 1'b1, 1'b0);
        door_closed = 1'b1;
`endif
        applyStimulus(OP_STOP, 4'd0);
        applyStimulus(OP_STOP, 4'd0);
        checkOutput("final_idle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl.md
# microwave_ctrl

Sequencing controller for the microwave datapath. It consumes the keypad encoder's digit bus, load strobe and multiplexed 1 Hz clock, and drives the encoder's `enablen` select. It accumulates a BCD cook time M:ST, runs the countdown, gates the magnetron and handles door, start and stop events. It sits between the keypad encoder and the 7-segment display/magnetron drivers.

## Interface
- `DONE_TICKS`, 3: number of 1 Hz ticks `done` is held before returning to IDLE (1..15).
- `clk` in 1: system clock (same clock as the encoder); all state on its rising edge.
- `clearn` in 1: asynchronous active-low reset.
- `D` in 4: digit from the encoder; valid when `loadn` is low.
- `loadn` in 1: encoder load strobe; low while a key is held.
- `pgt_1hz` in 1: encoder multiplexed output; a 1 Hz square wave while `enablen`=1.
- `startn` in 1: start button, active-low level.
- `stopn` in 1: stop/clear button, active-low level.
- `door_closed` in 1: 1 = door closed.
- `enablen` out 1: to the encoder; 0 = keypad active, 1 = select 1 Hz divider.
- `min_ones` out 4: BCD minutes, 0..9.
- `sec_tens` out 4: BCD seconds tens, 0..5.
- `sec_ones` out 4: BCD seconds ones, 0..9.
- `mag_on` out 1: magnetron enable.
- `done` out 1: cook-complete indication.

## Operation
- Input conditioning:
  - `loadn`, `pgt_1hz`, `startn` and `stopn` each pass through a 2-flop synchronizer.
  - Edge detectors on the synchronized signals produce single-cycle events:
    - key: `loadn` falling edge;
    - tick: `pgt_1hz` rising edge;
    - start: `startn` falling edge;
    - stop: `stopn` falling edge.
  - `D` is sampled on the key event. `D` is stable because the encoder holds it while `loadn` is low.
- States: IDLE, ENTRY, COOK, PAUSE, DONE. Reset enters IDLE.
- Reset values: state IDLE, all digits 0, `mag_on`=0, `done`=0, `enablen`=0, tick counter 0.
- IDLE/ENTRY, key event with `D`≤9:
  - Shift left: `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`D`. The old `min_ones` is discarded.
  - State becomes ENTRY.
  - The key is ignored (no change) if `D`>9 or if the current `sec_ones`>5, since that would make `sec_tens` illegal.
- IDLE/ENTRY, start event:
  - If the time is nonzero and the interlock passes, go to COOK.
  - Otherwise no change.
- COOK:
  - `enablen`=1 and `mag_on`=1.
  - Each tick decrements the time with borrow: `sec_ones` 0→9 borrows from `sec_tens`; `sec_tens` 0→5 borrows from `min_ones`.
  - When the decrement reaches 0:00, go to DONE.
- COOK, stop event or interlock fail: go to PAUSE. The time is held and `mag_on`=0.
- PAUSE:
  - `enablen`=1; key events are impossible and ignored.
  - Start event with the interlock passing returns to COOK.
  - Stop event clears the time and goes to IDLE.
- ENTRY, stop event: clear the time and go to IDLE.
- DONE:
  - `done`=1, `mag_on`=0, `enablen`=1.
  - Count ticks; after `DONE_TICKS` ticks go to IDLE with `done`=0.
  - Stop event goes to IDLE immediately.
- Simultaneous events:
  - Stop beats start.
  - Interlock fail beats tick: no decrement, go to PAUSE.
  - Tick and stop in COOK: go to PAUSE without decrementing.
- Arithmetic: all digits are 4-bit BCD. The minutes never underflow because DONE is entered at 0:00.

## Timing
- Input to event latency: 3 `clk` cycles (2 synchronizer flops + edge register). All outputs are registered and change on the cycle the state updates.
- Key latency: digits update 3 cycles after `loadn` falls.
- Start latency: `mag_on` and `enablen` rise 3 cycles after `startn` falls.
- Tick mask: after any 0→1 transition of `enablen`, tick events are masked for 4 cycles. This absorbs the encoder mux switching from debouncer to divider.
- Interlock (when compiled in): `door_closed` is synchronized by 2 flops, so `mag_on` falls 3 cycles after the door opens.
- Reset mid-operation: asserting `clearn` immediately forces all reset values, including `mag_on`=0, regardless of state.
- Button held: a held `startn`/`stopn` produces exactly one event.

## Configuration
- `MW_DOOR_INTERLOCK_EN` defined:
  - The interlock passes when synchronized `door_closed`=1.
  - Start requires the door to be closed.
  - The door opening in COOK forces PAUSE.
- Undefined:
  - The interlock always passes and `door_closed` is ignored.
  - The 2-flop `door_closed` synchronizer is omitted.

## Test plan
- Reset, then keys 1,3,0: display 1:30, state ENTRY, `enablen`=0, `mag_on`=0.
- Keys 7 then 4: display 0:07 after the 7; 4 is ignored because `sec_ones` 7>5, so the display stays 0:07.
- Load 1:00, start: `mag_on`=1 after 3 cycles; ticks give 0:59, 0:58, …, then 0:00 → `done`=1 for 3 ticks → IDLE with `mag_on`=0.
- (`MW_DOOR_INTERLOCK_EN`) At 0:10 in COOK, `door_closed`→0: PAUSE, `mag_on`=0, time frozen at 0:10. Start with the door open: no change. Close the door and start: resumes at 0:10.
- COOK at 0:05: assert `stopn` and a tick in the same cycle → PAUSE at 0:05. Second stop → IDLE at 0:00.
- Assert `clearn` low mid-COOK at 0:42: outputs immediately 0:00, `mag_on`=0, `enablen`=0, `done`=0.
